// File: rtl/reg_file_16x16.sv
// 16-entry register file with one synchronous write port and two
// combinational read ports. Register 0 can be hardwired to zero, and a
// write-through bypass can forward WriteData to a matching read port
// in the same cycle.
module reg_file_16x16 #(
  parameter int WIDTH   = 16,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             WriteEn,
  input  logic [3:0]       WriteAddr,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [3:0]       ReadAddrA,
  input  logic [3:0]       ReadAddrB,
  output logic [WIDTH-1:0] ReadDataA,
  output logic [WIDTH-1:0] ReadDataB,
  output logic             WriteAck
);

  logic [WIDTH-1:0] regs [16];
  logic             wr_allowed;

  // A write to R0 is dropped when R0 is hardwired; the ack still fires.
  assign wr_allowed = (WriteAddr != 4'd0) || !ZERO_R0;

  // Storage update; a plain if() means a non-1 strobe never writes anything.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
    end else if (WriteEn && wr_allowed) begin
      regs[WriteAddr] <= WriteData;
    end
  end

  // Write acknowledge: one-cycle-delayed copy of the write strobe.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      WriteAck <= 1'b0;
    end else begin
      WriteAck <= WriteEn;
    end
  end

  // Read port A: stored word, optionally forwarded write data, zero for R0.
  always_comb begin
    ReadDataA = regs[ReadAddrA];
    if (BYPASS && WriteEn && (WriteAddr == ReadAddrA)) begin
      ReadDataA = WriteData;
    end
    if (ZERO_R0 && (ReadAddrA == 4'd0)) begin
      ReadDataA = '0;
    end
  end

  // Read port B: same selection as port A, independent address.
  always_comb begin
    ReadDataB = regs[ReadAddrB];
    if (BYPASS && WriteEn && (WriteAddr == ReadAddrB)) begin
      ReadDataB = WriteData;
    end
    if (ZERO_R0 && (ReadAddrB == 4'd0)) begin
      ReadDataB = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_16x16.sv
`timescale 1ns/1ps
// Bench for reg_file_16x16: two instances share the stimulus, one with
// hardwired R0 + bypass (defaults), one with plain R0 and no bypass.
module tb_reg_file_16x16;

  logic        CLK;
  logic        Reset;
  logic        WriteEn;
  logic [3:0]  WriteAddr;
  logic [15:0] WriteData;
  logic [3:0]  ReadAddrA;
  logic [3:0]  ReadAddrB;
  logic [15:0] rda0, rdb0, rda1, rdb1;
  logic        ack0, ack1;

  int tests_run = 0;
  int tests_failed = 0;

  reg_file_16x16 #(.WIDTH(16), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut0 (
    .CLK(CLK), .Reset(Reset), .WriteEn(WriteEn), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
    .ReadDataA(rda0), .ReadDataB(rdb0), .WriteAck(ack0)
  );

  reg_file_16x16 #(.WIDTH(16), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut1 (
    .CLK(CLK), .Reset(Reset), .WriteEn(WriteEn), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
    .ReadDataA(rda1), .ReadDataB(rdb1), .WriteAck(ack1)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  // Reference model: plain arrays of stored words per configuration.
  logic [15:0] m0 [16];
  logic [15:0] m1 [16];
  logic        mack;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m0[i] = 16'h0000;
      m1[i] = 16'h0000;
    end
    mack = 1'b0;
  endtask

  // Architectural read: R0 rule first, then same-cycle forwarding, then storage.
  function automatic logic [15:0] mread(bit zero_r0, bit bypass, logic [3:0] a);
    if (zero_r0 && a == 4'd0) return 16'h0000;
    if (bypass && WriteEn === 1'b1 && WriteAddr == a) return WriteData;
    return zero_r0 ? m0[a] : m1[a];
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_a0"}, rda0, mread(1'b1, 1'b1, ReadAddrA));
    chk({tag, "_b0"}, rdb0, mread(1'b1, 1'b1, ReadAddrB));
    chk({tag, "_a1"}, rda1, mread(1'b0, 1'b0, ReadAddrA));
    chk({tag, "_b1"}, rdb1, mread(1'b0, 1'b0, ReadAddrB));
    chk({tag, "_ack0"}, {15'd0, ack0}, {15'd0, mack});
    chk({tag, "_ack1"}, {15'd0, ack1}, {15'd0, mack});
  endtask

  // One clock: capture the write the model should commit, wait past the edge.
  task automatic cycle();
    logic        we_s;
    logic [3:0]  wa_s;
    logic [15:0] wd_s;
    we_s = (WriteEn === 1'b1) && (Reset === 1'b0);
    wa_s = WriteAddr;
    wd_s = WriteData;
    @(posedge CLK);
    if (we_s) begin
      if (wa_s != 4'd0) m0[wa_s] = wd_s;
      m1[wa_s] = wd_s;
    end
    mack = we_s;
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] ea0, eb0, ea1, eb1;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(logic we, int wa, logic [15:0] wd, int ra, int rb,
                         logic [15:0] ea0, logic [15:0] eb0,
                         logic [15:0] ea1, logic [15:0] eb1);
    vec_t v;
    v.we = we; v.wa = 4'(wa); v.wd = wd; v.ra = 4'(ra); v.rb = 4'(rb);
    v.ea0 = ea0; v.eb0 = eb0; v.ea1 = ea1; v.eb1 = eb1;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Directed vectors, starting from an all-zero file.
    for (int n = 1; n < 16; n++)
      add_vec(1'b1, n, 16'(n), n, n, 16'(n), 16'(n), 16'h0, 16'h0);
    for (int i = 0; i < 16; i++)
      add_vec(1'b0, 0, 16'h0, i, 15 - i, 16'(i), 16'(15 - i), 16'(i), 16'(15 - i));
    add_vec(1'b1, 0, 16'hBEEF, 0, 1, 16'h0, 16'h1, 16'h0, 16'h1);
    add_vec(1'b0, 0, 16'h0, 0, 15, 16'h0, 16'hF, 16'hBEEF, 16'hF);
    for (int i = 1; i < 16; i++)
      add_vec(1'b0, 0, 16'h0, i, i, 16'(i), 16'(i), 16'(i), 16'(i));
    add_vec(1'b1, 5, 16'h1234, 5, 5, 16'h1234, 16'h1234, 16'h0005, 16'h0005);
    add_vec(1'b1, 5, 16'hABCD, 5, 5, 16'hABCD, 16'hABCD, 16'h1234, 16'h1234);
    add_vec(1'b0, 0, 16'h0, 5, 3, 16'hABCD, 16'h0003, 16'hABCD, 16'h0003);

    Reset = 1'b1; WriteEn = 1'b0; WriteAddr = 4'd0; WriteData = 16'h0;
    ReadAddrA = 4'd0; ReadAddrB = 4'd15;
    model_clear();
    #5;
    check_all("por");
    cycle();
    cycle();
    Reset = 1'b0;
    cycle();

    // Test 1: fill with FFFF, then asynchronous reset between edges.
    for (int i = 0; i < 16; i++) begin
      WriteEn = 1'b1; WriteAddr = 4'(i); WriteData = 16'hFFFF;
      ReadAddrA = 4'(i); ReadAddrB = 4'((i + 1) % 16);
      #1;
      check_all("fill_ffff");
      cycle();
    end
    WriteEn = 1'b0; ReadAddrA = 4'd15; ReadAddrB = 4'd0;
    #1;
    chk("pre_reset_a0", rda0, 16'hFFFF);
    chk("pre_reset_b1", rdb1, 16'hFFFF);
    chk("pre_reset_ack", {15'd0, ack0}, 16'h0001);
    #3;
    Reset = 1'b1;
    model_clear();
    for (int i = 0; i < 16; i++) begin
      ReadAddrA = 4'(i); ReadAddrB = 4'(15 - i);
      #1;
      chk("async_rst_a0", rda0, 16'h0);
      chk("async_rst_b0", rdb0, 16'h0);
      chk("async_rst_a1", rda1, 16'h0);
      chk("async_rst_b1", rdb1, 16'h0);
    end
    chk("async_rst_ack0", {15'd0, ack0}, 16'h0);
    chk("async_rst_ack1", {15'd0, ack1}, 16'h0);
    cycle();
    Reset = 1'b0;
    cycle();

    // Tests 2-4: table of directed vectors.
    foreach (vecs[k]) begin
      WriteEn = vecs[k].we; WriteAddr = vecs[k].wa; WriteData = vecs[k].wd;
      ReadAddrA = vecs[k].ra; ReadAddrB = vecs[k].rb;
      #1;
      chk("vec_a0", rda0, vecs[k].ea0);
      chk("vec_b0", rdb0, vecs[k].eb0);
      chk("vec_a1", rda1, vecs[k].ea1);
      chk("vec_b1", rdb1, vecs[k].eb1);
      check_all("vec_model");
      cycle();
    end

    // Test 5: write held across edges while in reset is lost.
    Reset = 1'b1; WriteEn = 1'b1; WriteAddr = 4'd7; WriteData = 16'h5555;
    ReadAddrA = 4'd7; ReadAddrB = 4'd7;
    model_clear();
    cycle();
    cycle();
    Reset = 1'b0; WriteEn = 1'b0;
    #1;
    chk("rst_write_r7_0", rda0, 16'h0);
    chk("rst_write_r7_1", rda1, 16'h0);
    chk("rst_write_ack0", {15'd0, ack0}, 16'h0);
    chk("rst_write_ack1", {15'd0, ack1}, 16'h0);
    cycle();
    chk("rst_write_ack_after", {15'd0, ack0}, 16'h0);
    chk("rst_write_r7_after", rdb1, 16'h0);

    // Test 6: back-to-back writes keep the ack high for three cycles.
    WriteEn = 1'b1; WriteAddr = 4'd3; WriteData = 16'h0003;
    cycle();
    chk("b2b_ack_1", {15'd0, ack0}, 16'h1);
    WriteAddr = 4'd3; WriteData = 16'h0033;
    cycle();
    chk("b2b_ack_2", {15'd0, ack0}, 16'h1);
    WriteAddr = 4'd4; WriteData = 16'h0044;
    cycle();
    chk("b2b_ack_3", {15'd0, ack1}, 16'h1);
    WriteEn = 1'b0;
    cycle();
    ReadAddrA = 4'd3; ReadAddrB = 4'd4;
    #1;
    chk("b2b_ack_low", {15'd0, ack0}, 16'h0);
    chk("b2b_r3_0", rda0, 16'h0033);
    chk("b2b_r4_0", rdb0, 16'h0044);
    chk("b2b_r3_1", rda1, 16'h0033);
    chk("b2b_r4_1", rdb1, 16'h0044);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      WriteEn   = ($urandom_range(0, 3) != 0);
      WriteAddr = 4'($urandom_range(0, 15));
      WriteData = 16'($urandom);
      ReadAddrA = ($urandom_range(0, 3) == 0) ? WriteAddr : 4'($urandom_range(0, 15));
      ReadAddrB = ($urandom_range(0, 3) == 0) ? WriteAddr : 4'($urandom_range(0, 15));
      #1;
      check_all("rand");
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_file_16x16.md
Name: reg_file_16x16

Overview:
- 16-entry × 16-bit processor register file.
- Holds the architectural registers whose contents feed the 16:1 read-select mux stage.
- One synchronous write port, two asynchronous read ports (A, B). Each read port is equivalent to the Mux16x16 selection over the stored words.
- Optional write-through bypass and hardwired-zero register 0, set by parameter.

Parameters:
- WIDTH, 16, data width of each register.
- ZERO_R0, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary storage.
- BYPASS, 1, 1 = a read of the address being written this cycle returns WriteData; 0 = it returns the stored (old) value.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; clears all registers.
- WriteEn  input  1  write strobe, sampled at rising CLK.
- WriteAddr  input  4  destination register index.
- WriteData  input  WIDTH  data to write.
- ReadAddrA  input  4  read port A register index.
- ReadAddrB  input  4  read port B register index.
- ReadDataA  output  WIDTH  contents of register ReadAddrA.
- ReadDataB  output  WIDTH  contents of register ReadAddrB.
- WriteAck  output  1  registered pulse: high for one cycle after a write is committed.

Behaviour:
- Storage: 16 registers R0..R15, each WIDTH bits.
- Reset:
  - Reset high immediately clears R0..R15 to 0 and WriteAck to 0, without waiting for a clock edge.
  - While Reset is high, WriteEn is ignored.
  - A write coincident with Reset assertion is lost.
  - Deassertion takes effect at the first rising CLK with Reset low.
- Write:
  - On rising CLK with WriteEn=1, R[WriteAddr] <= WriteData.
  - Exactly one register changes; all others hold.
  - The write is visible in storage from the following cycle.
- Register 0 with ZERO_R0=1:
  - Writes to address 0 are discarded.
  - WriteAck still pulses, since the instruction completed.
  - Reads of address 0 return 0 regardless of BYPASS.
- Read:
  - ReadDataA = R[ReadAddrA] and ReadDataB = R[ReadAddrB], purely combinational with zero-cycle latency.
  - Both ports may address the same register; both return the identical value.
- Bypass with BYPASS=1:
  - If WriteEn=1 and WriteAddr equals a read address (non-zero, or any address if ZERO_R0=0), that port returns WriteData combinationally in the same cycle.
  - This applies independently per port.
  - With BYPASS=0, the port returns the old value until the edge.
- WriteAck:
  - Registered: WriteAck <= WriteEn at each rising CLK.
  - Back-to-back writes hold it high continuously.
- Addressing: all 4-bit addresses are valid; there is no out-of-range case.
- Widths: there is no arithmetic; data passes unmodified and WriteData is stored at full WIDTH.
- X handling: a bench asserting WriteEn=X must not corrupt registers other than the addressed one.

Test Plan:
1. Reset clears all registers. Write 0xFFFF to every address, then pulse Reset mid-cycle (asynchronous, between edges). Require all 16 reads to return 0x0000 immediately, before the next CLK edge, and WriteAck=0.
2. Fill and sweep. Write Rn = 0x0000+n for n=1..15. Sweep ReadAddrA over 0..15 and ReadAddrB over 15..0. Require A=n and B=15-n on each step. R0 reads 0x0000 (ZERO_R0=1).
3. Zero-register protection. Write 0xBEEF to address 0. Require ReadDataA at address 0 = 0x0000, WriteAck=1 on the next cycle, and R1..R15 unchanged.
4. Bypass. R5 = 0x1234; in the same cycle, WriteEn=1, WriteAddr=5, WriteData=0xABCD, ReadAddrA=5, ReadAddrB=5.
   - BYPASS=1: both ports read 0xABCD before the edge.
   - BYPASS=0: both read 0x1234 before the edge and 0xABCD after it.
5. Write during reset. With Reset=1, WriteEn=1, WriteAddr=7, WriteData=0x5555 across two edges, then release Reset. Require R7=0x0000 and WriteAck=0.
6. Back-to-back writes. Three consecutive cycles write R3=0x0003, R3=0x0033, R4=0x0044. Require WriteAck high for three cycles, then low. Final state R3=0x0033, R4=0x0044.
